xyt_frame_rx: RTL
=================

XYT_FRAME_RX -- requirements
Module: xyt_frame_rx

Interface
REQ-001 Parameter TIMEOUT, default 255, is the maximum number of clk cycles allowed between bit strobes inside a frame.
REQ-002 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 Port rst_n, input, 1: reset, synchronous and active-low.
REQ-004 Port sync, input, 1: frame-start pulse, one clk cycle.
REQ-005 Port sdi, input, 1: serial data bit, valid only when sdi_vld=1.
REQ-006 Port sdi_vld, input, 1: bit strobe, one clk cycle per bit.
REQ-007 Port frame_out, output, 8: {p[1:0], t[1:0], y[1:0], x[1:0]}; drives the moving-average stage's ui_in[7:0] directly.
REQ-008 Port frame_stb, output, 1: one-cycle pulse on each accepted frame.
REQ-009 Port err_cnt, output, 4: saturating count of rejected frames.
REQ-010 Port busy, output, 1: high in any state other than IDLE.

Function
REQ-011 The FSM SHALL have states IDLE, DATA, PARITY and STOP.
REQ-012 Frame format: sync, then 6 data bits MSB first (t1,t0,y1,y0,x1,x0), then 1 parity bit, then 1 stop bit; one bit per sdi_vld.
REQ-013 IDLE: sync=1 -> DATA with bit_cnt=0 and shift register cleared; sdi_vld ignored in IDLE.
REQ-014 DATA: each sdi_vld shifts sdi into the 6-bit shift register at the LSB and increments bit_cnt; after the 6th bit -> PARITY.
REQ-015 PARITY: sdi_vld captures the parity bit -> STOP; parity is even, i.e. XOR of the 6 data bits and the parity bit must be 0.
REQ-016 STOP: sdi_vld ends the frame -> IDLE; the frame is good iff parity is correct and the stop bit = 1.
REQ-017 Good frame: on the clk edge after the stop-bit strobe, frame_out = {2'b11, t, y, x} and frame_stb=1 for exactly one cycle.
REQ-018 Bad frame (parity or stop error): frame_out = 8'h00 on that edge, frame_stb stays 0, err_cnt increments.
REQ-019 frame_out SHALL hold its last value between frames, so p stays 11 after a good frame until the next bad frame or abort.
REQ-020 Timeout: an 8-bit counter clears on each sdi_vld and on entry to DATA; if it reaches TIMEOUT while busy -> IDLE, frame_out=8'h00, err_cnt increments.
REQ-021 sync while busy: abort the current frame (err_cnt increments, frame_out=8'h00) and restart in DATA with bit_cnt=0 on the same edge.
REQ-022 sync and sdi_vld in the same cycle: sync wins and that bit is discarded, in every state.
REQ-023 err_cnt SHALL saturate at 4'hF and never wrap.
REQ-024 Exactly one err_cnt increment per rejected frame, even if an error and a timeout coincide.
REQ-025 busy = 1 in DATA, PARITY and STOP.
REQ-026 Latency from the stop-bit strobe to frame_out update is exactly 1 clk.

Reset
REQ-027 While rst_n=0 at a clk edge: FSM -> IDLE; bit_cnt, shift register and timeout counter = 0.
REQ-028 Output reset values: frame_out=8'h00, frame_stb=0, err_cnt=0, busy=0.
REQ-029 Reset mid-frame SHALL discard the partial frame with no err_cnt increment.
REQ-030 Reset overrides sync and sdi_vld in the same cycle.

Verification
REQ-031 Good frame: sync, bits 1,0,0,1,1,1, parity 0, stop 1 -> frame_out=8'hE7 one cycle after the stop strobe, frame_stb one pulse, err_cnt=0.
REQ-032 Parity error: same frame with parity 1 -> frame_out=8'h00, no frame_stb, err_cnt=1.
REQ-033 Stop error: valid data and parity, stop bit 0 -> frame_out=8'h00, err_cnt=1.
REQ-034 Timeout and resync: start a frame, stall TIMEOUT cycles -> busy=0, err_cnt+1; sync asserted with sdi_vld after 3 bits -> restart, that bit discarded, err_cnt+1.
REQ-035 Saturation: 17 bad frames -> err_cnt=4'hF.
REQ-036 Reset mid-frame: assert rst_n=0 after 4 bits -> all outputs at reset values, err_cnt unchanged at 0, next full good frame received correctly.

Source files
------------

// File: rtl/xyt_frame_rx.sv
// Serial frame receiver: sync pulse, 6 data bits MSB first, even parity, stop bit.
// Accepted frames appear as {2'b11, t, y, x} one clock after the stop strobe.
module xyt_frame_rx #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sync,
   input  logic       sdi,
   input  logic       sdi_vld,
   output logic [7:0] frame_out,
   output logic       frame_stb,
   output logic [3:0] err_cnt,
   output logic       busy
);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   // A stalled frame is dropped on the edge where the idle-cycle count would reach TIMEOUT.
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   state_t     state, state_d;
   logic [5:0] sreg, sreg_d;
   logic [2:0] bit_cnt, bit_cnt_d;
   logic       par, par_d;
   logic [7:0] tcnt, tcnt_d;
   logic [7:0] fo_d;
   logic       stb_d;
   logic       err_inc;
   logic       tmo;
   logic       frame_good;

   assign busy       = (state != IDLE);
   assign tmo        = busy && !sdi_vld && (tcnt == TMO_LAST);
   assign frame_good = !(^sreg ^ par) && sdi;

   // State and output registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         sreg      <= '0;
         bit_cnt   <= '0;
         par       <= 1'b0;
         tcnt      <= '0;
         frame_out <= '0;
         frame_stb <= 1'b0;
         err_cnt   <= '0;
      end else begin
         state     <= state_d;
         sreg      <= sreg_d;
         bit_cnt   <= bit_cnt_d;
         par       <= par_d;
         tcnt      <= tcnt_d;
         frame_out <= fo_d;
         frame_stb <= stb_d;
         if (err_inc && (err_cnt != 4'hF))
            err_cnt <= err_cnt + 4'd1;
      end
   end

   // Next state; sync outranks a strobe, which outranks the timeout
   always_comb begin
      state_d   = state;
      sreg_d    = sreg;
      bit_cnt_d = bit_cnt;
      par_d     = par;
      tcnt_d    = tcnt;
      if (sync) begin
         state_d   = DATA;
         sreg_d    = '0;
         bit_cnt_d = '0;
         tcnt_d    = '0;
      end else if (busy) begin
         if (sdi_vld) begin
            tcnt_d = '0;
            case (state)
               DATA: begin
                  sreg_d    = {sreg[4:0], sdi};
                  bit_cnt_d = bit_cnt + 3'd1;
                  if (bit_cnt == 3'd5)
                     state_d = PARITY;
               end
               PARITY: begin
                  par_d   = sdi;
                  state_d = STOP;
               end
               STOP:    state_d = IDLE;
               default: state_d = IDLE;
            endcase
         end else if (tmo) begin
            state_d = IDLE;
            tcnt_d  = '0;
         end else begin
            tcnt_d = tcnt + 8'd1;
         end
      end
   end

   // Frame result; every rejection path raises err_inc exactly once
   always_comb begin
      fo_d    = frame_out;
      stb_d   = 1'b0;
      err_inc = 1'b0;
      if (sync) begin
         if (busy) begin
            fo_d    = '0;
            err_inc = 1'b1;
         end
      end else if ((state == STOP) && sdi_vld) begin
         if (frame_good) begin
            fo_d  = {2'b11, sreg};
            stb_d = 1'b1;
         end else begin
            fo_d    = '0;
            err_inc = 1'b1;
         end
      end else if (tmo) begin
         fo_d    = '0;
         err_inc = 1'b1;
      end
   end

endmodule
